// File: rtl/gpio_cfg_arbiter.sv
// gpio_cfg_arbiter: round-robin arbiter serialising two requesters' config writes onto the GPIO config bus
//   clk, rst (async, active-high)
//   req_valid[1:0], req_addr0/1[15:0], req_data0/1[7:0] : requester write ports
//   req_ready[1:0] : accept, asserted only in IDLE for the granted requester
//   gpio_out[31:0] : {7'b0, w_clk, data, addr}, fully registered
//   busy, done[1:0] (last HOLD cycle pulse), wr_count[15:0] (completed writes)
module gpio_cfg_arbiter #(
  parameter int SETUP_CYC = 2,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_addr0,
  input  logic [7:0]  req_data0,
  input  logic [15:0] req_addr1,
  input  logic [7:0]  req_data1,
  output logic [1:0]  req_ready,
  output logic [31:0] gpio_out,
  output logic        busy,
  output logic [1:0]  done,
  output logic [15:0] wr_count
);
  localparam int MAX_SP = SETUP_CYC > PULSE_CYC ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_C  = MAX_SP > HOLD_CYC ? MAX_SP : HOLD_CYC;
  localparam int CW     = $clog2(MAX_C + 1);
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   addr_q;
  logic [7:0]    data_q;
  logic          wclk;
  logic          g_q;
  logic          rr_last;
  logic          g;
  // contention goes to whoever was not granted last; a lone request wins outright
  always_comb g = (&req_valid) ? ~rr_last : req_valid[1];
  assign req_ready = (state == IDLE && |req_valid) ? (g ? 2'b10 : 2'b01) : 2'b00;
  assign gpio_out  = {7'b0, wclk, data_q, addr_q};
  assign busy      = state != IDLE;
  assign done      = (state == HOLD && cnt == '0) ? {g_q, ~g_q} : 2'b00;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wclk     <= 1'b0;
      g_q      <= 1'b0;
      rr_last  <= 1'b1;
      wr_count <= '0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          addr_q  <= g ? req_addr1 : req_addr0;
          data_q  <= g ? req_data1 : req_data0;
          g_q     <= g;
          rr_last <= g;
          cnt     <= CW'(SETUP_CYC - 1);
          state   <= SETUP;
        end
        SETUP: if (cnt == '0) begin
          cnt   <= CW'(PULSE_CYC - 1);
          wclk  <= 1'b1;
          state <= STROBE;
        end else cnt <= cnt - 1'b1;
        STROBE: if (cnt == '0) begin
          cnt   <= CW'(HOLD_CYC - 1);
          wclk  <= 1'b0;
          state <= HOLD;
        end else cnt <= cnt - 1'b1;
        HOLD: if (cnt == '0) begin
          wr_count <= wr_count + 16'd1;
          state    <= IDLE;
        end else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_gpio_cfg_arbiter.sv
// tb_gpio_cfg_arbiter: randomized and directed checks of gpio_cfg_arbiter against a write-timeline model
module tb_gpio_cfg_arbiter;
  localparam int S = 2, P = 2, H = 2;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid, req_ready, done;
  logic [15:0] req_addr0, req_addr1, wr_count;
  logic [7:0]  req_data0, req_data1;
  logic [31:0] gpio_out;
  logic        busy;
  logic [1:0]  u1_valid, u1_ready, u1_done;
  logic [15:0] u1_addr0, u1_addr1, u1_count;
  logic [7:0]  u1_data0, u1_data1;
  logic [31:0] u1_gpio;
  logic        u1_busy;
  gpio_cfg_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr0(req_addr0), .req_data0(req_data0),
    .req_addr1(req_addr1), .req_data1(req_data1), .req_ready(req_ready), .gpio_out(gpio_out),
    .busy(busy), .done(done), .wr_count(wr_count)
  );
  gpio_cfg_arbiter #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(u1_valid), .req_addr0(u1_addr0), .req_data0(u1_data0),
    .req_addr1(u1_addr1), .req_data1(u1_data1), .req_ready(u1_ready), .gpio_out(u1_gpio),
    .busy(u1_busy), .done(u1_done), .wr_count(u1_count)
  );
  always #5 clk = ~clk;
  int checks = 0, errs = 0;
  // model: k = cycles since the handshake of the write in flight (0 = idle)
  int          k;
  logic        m_g, m_rr;
  logic [15:0] m_addr, m_cnt;
  logic [7:0]  m_data;
  logic [1:0]  hs;
  int          cyc = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    k = 0; m_g = 0; m_rr = 1; m_addr = 0; m_data = 0; m_cnt = 0; hs = 0;
  endtask
  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_reset();
  endtask
  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    if (hs != 0) begin
      k = 1; m_g = hs[1]; m_rr = hs[1];
      m_addr = hs[1] ? req_addr1 : req_addr0;
      m_data = hs[1] ? req_data1 : req_data0;
    end else if (k == S + P + H) begin
      k = 0; m_cnt++;
    end else if (k != 0) k++;
  endtask
  task automatic drive_check(input logic [1:0] v, input logic [15:0] a0, input logic [7:0] d0,
                             input logic [15:0] a1, input logic [7:0] d1);
    logic [1:0] er;
    logic       wc;
    req_valid = v; req_addr0 = a0; req_data0 = d0; req_addr1 = a1; req_data1 = d1;
    #1;
    er = (k == 0 && v != 0) ? ((v == 2'b11) ? (m_rr ? 2'b01 : 2'b10) : v) : 2'b00;
    wc = (k >= S + 1) && (k <= S + P);
    check("ready", {30'd0, req_ready}, {30'd0, er});
    check("gpio", gpio_out, {7'd0, wc, m_data, m_addr});
    check("busy", {31'd0, busy}, {31'd0, k != 0});
    check("done", {30'd0, done}, (k == S + P + H) ? (m_g ? 32'd2 : 32'd1) : 32'd0);
    check("wr_count", {16'd0, wr_count}, {16'd0, m_cnt});
    hs = er & v;
  endtask
  initial begin
    logic [1:0]  pend;
    logic [15:0] pa [2];
    logic [7:0]  pd [2];
    int ng, last_t, hs_j;
    req_valid = 0; req_addr0 = 0; req_data0 = 0; req_addr1 = 0; req_data1 = 0;
    u1_valid = 0; u1_addr0 = 0; u1_data0 = 0; u1_addr1 = 0; u1_data1 = 0;
    do_reset();
    check("rst_gpio", gpio_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    // single write from requester 0
    tick(); drive_check(2'b01, 16'h0010, 8'hA5, 16'h0, 8'h0);
    check("t1_ready", {30'd0, req_ready}, 32'd1);
    for (int j = 1; j <= 7; j++) begin
      tick(); drive_check(2'b00, 16'h0, 8'h0, 16'h0, 8'h0);
      if (j <= 6) check("t1_bus", gpio_out, (j == 3 || j == 4) ? 32'h01A50010 : 32'h00A50010);
      check("t1_done", {30'd0, done}, (j == 6) ? 32'd1 : 32'd0);
    end
    check("t1_count", {16'd0, wr_count}, 32'd1);
    // both valid continuously: strict alternation, one handshake every 7 cycles
    do_reset();
    ng = 0; last_t = -1;
    for (int j = 0; j < 40; j++) begin
      tick(); drive_check(ng < 4 ? 2'b11 : 2'b00, 16'h0001, 8'h11, 16'h0002, 8'h22);
      if (hs != 0) begin
        check("t2_order", {30'd0, hs}, (ng % 2) ? 32'd2 : 32'd1);
        if (last_t >= 0) check("t2_period", cyc - last_t, 7);
        last_t = cyc; ng++;
      end
    end
    check("t2_grants", ng, 4);
    check("t2_count", {16'd0, wr_count}, 32'd4);
    // requester 1 arrives mid-write and waits
    tick(); drive_check(2'b01, 16'h0033, 8'h3C, 16'h0, 8'h0);
    hs_j = -1;
    for (int j = 1; j <= 16; j++) begin
      tick(); drive_check((j >= 2 && hs_j < 0) ? 2'b10 : 2'b00, 16'h0, 8'h0, 16'h0044, 8'h77);
      if (hs != 0 && hs_j < 0) hs_j = j;
    end
    check("t3_wait", hs_j, 7);
    // reset during STROBE aborts the write, then requester 0 wins contention
    tick(); drive_check(2'b01, 16'h0055, 8'h66, 16'h0, 8'h0);
    for (int j = 1; j <= 3; j++) begin
      tick(); drive_check(2'b00, 16'h0, 8'h0, 16'h0, 8'h0);
    end
    check("t4_wclk_pre", {31'd0, gpio_out[24]}, 32'd1);
    #1 rst = 1;
    #1;
    check("t4_gpio", gpio_out, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    check("t4_done", {30'd0, done}, 32'd0);
    check("t4_count", {16'd0, wr_count}, 32'd0);
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    tick(); drive_check(2'b11, 16'h0101, 8'h01, 16'h0202, 8'h02);
    check("t4_win", {30'd0, hs}, 32'd1);
    for (int j = 1; j <= 8; j++) begin
      tick(); drive_check(2'b00, 16'h0, 8'h0, 16'h0, 8'h0);
    end
    // randomized traffic; requesters hold until accepted, occasionally withdraw
    pend = 0; pa[0] = 0; pa[1] = 0; pd[0] = 0; pd[1] = 0;
    for (int j = 0; j < 3000; j++) begin
      tick();
      for (int n = 0; n < 2; n++) begin
        if (hs[n]) pend[n] = 0;
        if (pend[n] && $urandom_range(60) == 0) pend[n] = 0;
        if (!pend[n] && $urandom_range(3) == 0) begin
          pend[n] = 1; pa[n] = 16'($urandom); pd[n] = 8'($urandom);
        end
      end
      drive_check(pend, pa[0], pd[0], pa[1], pd[1]);
    end
    // single-cycle phases
    @(posedge clk); #1;
    u1_valid = 2'b01; u1_addr0 = 16'h1234; u1_data0 = 8'h5A;
    #1 check("u1_ready", {30'd0, u1_ready}, 32'd1);
    @(posedge clk); #1;
    u1_valid = 2'b00;
    #1 check("u1_setup", u1_gpio, 32'h005A1234);
    @(posedge clk); #2;
    check("u1_strobe", u1_gpio, 32'h015A1234);
    check("u1_nodone", {30'd0, u1_done}, 32'd0);
    @(posedge clk); #2;
    check("u1_hold", u1_gpio, 32'h005A1234);
    check("u1_done", {30'd0, u1_done}, 32'd1);
    @(posedge clk); #2;
    check("u1_idle", {31'd0, u1_busy}, 32'd0);
    check("u1_count", {16'd0, u1_count}, 32'd1);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
    $finish;
  end
endmodule
